// File: rtl/ttl_jk_array_sync_if.sv
// Bundles the per-channel control inputs and flip-flop outputs of the
// J-K flip-flop array. The master drives the controls; the slave is the array.
interface ttl_jk_array_sync_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] CLRn;
    logic [CHANNELS-1:0] PREn;
    logic [CHANNELS-1:0] J;
    logic [CHANNELS-1:0] K;
    logic [CHANNELS-1:0] Cen;
    logic [CHANNELS-1:0] Q;
    logic [CHANNELS-1:0] Qn;
    logic [CHANNELS-1:0] Ev;

    modport master (output CLRn, PREn, J, K, Cen, input Q, Qn, Ev);
    modport slave  (input CLRn, PREn, J, K, Cen, output Q, Qn, Ev);
endinterface

// File: rtl/ttl_jk_array_sync.sv
// Bank of J-K flip-flops emulating TTL parts on a single system clock.
// Each channel is "clocked" by a trigger level sampled on Clk; an edge on
// that level acts like the part's clock edge. Optional ripple cascading
// drives channel i from the stored state of channel i-1.

// One J-K flip-flop with its trigger history and both-low flag.
module ttl_jk_cell #(
    parameter int   EDGE     = 0,
    parameter int   JKBAR    = 0,
    parameter logic INIT_BIT = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic primed,
    input  logic clr_n,
    input  logic pre_n,
    input  logic j,
    input  logic k,
    input  logic tsrc,
    output logic s,
    output logic b,
    output logic ev
);
    localparam logic ACT = (EDGE != 0);

    logic h;
    logic ke;
    logic trig;

    assign ke   = (JKBAR != 0) ? ~k : k;
    // History is only meaningful once primed, so the first cycle never fires.
    assign trig = primed && (h != tsrc) && (tsrc == ACT);

    // State, history and event pulse; clear/preset override any trigger edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s  <= INIT_BIT;
            b  <= 1'b0;
            ev <= 1'b0;
            h  <= ~ACT;
        end else begin
            h  <= tsrc;
            ev <= 1'b0;
            if (primed) begin
                if (!clr_n && !pre_n) begin
                    s <= 1'b0;
                    b <= 1'b1;
                end else if (!clr_n) begin
                    s <= 1'b0;
                    b <= 1'b0;
                end else if (!pre_n) begin
                    s <= 1'b1;
                    b <= 1'b0;
                end else begin
                    b <= 1'b0;
                    if (trig) begin
                        ev <= 1'b1;
                        case ({j, ke})
                            2'b01:   s <= 1'b0;
                            2'b10:   s <= 1'b1;
                            2'b11:   s <= ~s;
                            default: s <= s;
                        endcase
                    end
                end
            end
        end
    end
endmodule

module ttl_jk_array_sync #(
    parameter int                 CHANNELS = 4,
    parameter int                 EDGE     = 0,
    parameter int                 JKBAR    = 0,
    parameter int                 CASCADE  = 0,
    parameter logic [CHANNELS-1:0] INIT    = {CHANNELS{1'b0}}
) (
    input  logic             Clk,
    input  logic             Reset,
    ttl_jk_array_sync_if.slave bus
);
    logic                primed;
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] b;
    logic [CHANNELS-1:0] ev;
    logic [CHANNELS-1:0] tsrc;

    // Shared priming flag: set on the first Clk after reset release.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) primed <= 1'b0;
        else       primed <= 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Ripple stages follow the registered state of the previous stage.
        if (i == 0) begin : g_src0
            assign tsrc[i] = bus.Cen[i];
        end else begin : g_srcn
            assign tsrc[i] = (CASCADE != 0) ? s[i-1] : bus.Cen[i];
        end

        ttl_jk_cell #(
            .EDGE     (EDGE),
            .JKBAR    (JKBAR),
            .INIT_BIT (INIT[i])
        ) u_cell (
            .Clk    (Clk),
            .Reset  (Reset),
            .primed (primed),
            .clr_n  (bus.CLRn[i]),
            .pre_n  (bus.PREn[i]),
            .j      (bus.J[i]),
            .k      (bus.K[i]),
            .tsrc   (tsrc[i]),
            .s      (s[i]),
            .b      (b[i]),
            .ev     (ev[i])
        );
    end

    // Both outputs high while clear and preset are both held low.
    assign bus.Q  = s | b;
    assign bus.Qn = ~s | b;
    assign bus.Ev = ev;
endmodule

// File: tb/tb_ttl_jk_array_sync.sv
// Directed bench for the J-K array. Three instances cover the plain
// falling-edge bank, the J/K-bar rising bank and a 4-stage ripple counter.
// Every Ev pulse is matched against an expected {Ev,Q} queued by the stimulus.
module tb_ttl_jk_array_sync;
    typedef struct packed {
        logic [3:0] ev;
        logic [3:0] q;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    always #5 Clk = ~Clk;

    ttl_jk_array_sync_if #(.CHANNELS(2)) b0 ();
    ttl_jk_array_sync_if #(.CHANNELS(2)) b1 ();
    ttl_jk_array_sync_if #(.CHANNELS(4)) b2 ();

    ttl_jk_array_sync #(.CHANNELS(2), .EDGE(0), .JKBAR(0), .CASCADE(0), .INIT(2'b10))
        d0 (.Clk(Clk), .Reset(Reset), .bus(b0));
    ttl_jk_array_sync #(.CHANNELS(2), .EDGE(1), .JKBAR(1), .CASCADE(0), .INIT(2'b00))
        d1 (.Clk(Clk), .Reset(Reset), .bus(b1));
    ttl_jk_array_sync #(.CHANNELS(4), .EDGE(0), .JKBAR(0), .CASCADE(1), .INIT(4'h0))
        d2 (.Clk(Clk), .Reset(Reset), .bus(b2));

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitors: one per instance, triggered by any Ev pulse.
    always @(negedge Clk) begin
        exp_t e;
        if (b0.Ev !== 2'b00) begin
            if (sb0.size() == 0) chk("sb0_unexpected_ev", {2'b00, b0.Ev}, 4'h0);
            else begin
                e = sb0.pop_front();
                chk("sb0_ev", {2'b00, b0.Ev}, e.ev);
                chk("sb0_q", {2'b00, b0.Q}, e.q);
            end
        end
        if (b1.Ev !== 2'b00) begin
            if (sb1.size() == 0) chk("sb1_unexpected_ev", {2'b00, b1.Ev}, 4'h0);
            else begin
                e = sb1.pop_front();
                chk("sb1_ev", {2'b00, b1.Ev}, e.ev);
                chk("sb1_q", {2'b00, b1.Q}, e.q);
            end
        end
        if (b2.Ev !== 4'h0) begin
            if (sb2.size() == 0) chk("sb2_unexpected_ev", b2.Ev, 4'h0);
            else begin
                e = sb2.pop_front();
                chk("sb2_ev", b2.Ev, e.ev);
                chk("sb2_q", b2.Q, e.q);
            end
        end
    end

    initial begin
        logic [1:0] jk_tab [5];
        logic       q_tab  [5];
        logic [1:0] q1;
        logic [3:0] c;
        logic [3:0] qe;
        logic [3:0] ee;
        bit         go;

        jk_tab = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        q_tab  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        b0.CLRn = '1; b0.PREn = '1; b0.J = '0; b0.K = '0; b0.Cen = '0;
        b1.CLRn = '1; b1.PREn = '1; b1.J = '0; b1.K = '0; b1.Cen = '0;
        b2.CLRn = '1; b2.PREn = '1; b2.J = '0; b2.K = '0; b2.Cen = '0;

        // Reset state and priming with trigger already at active level
        tick(); tick();
        chk("rst_q", {2'b00, b0.Q}, 4'b0010);
        chk("rst_qn", {2'b00, b0.Qn}, 4'b0001);
        chk("rst_ev", {2'b00, b0.Ev}, 4'b0000);
        chk("rst_q_ripple", b2.Q, 4'h0);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("prime_q", {2'b00, b0.Q}, 4'b0010);
            chk("prime_ev", {2'b00, b0.Ev}, 4'b0000);
        end

        // J/K truth table on channel 0, falling trigger
        for (int i = 0; i < 5; i++) begin
            b0.J[0] = jk_tab[i][1];
            b0.K[0] = jk_tab[i][0];
            b0.Cen[0] = 1'b1;
            tick(); tick();
            chk("jk_rise_no_ev", {2'b00, b0.Ev}, 4'b0000);
            b0.Cen[0] = 1'b0;
            sb0.push_back('{ev: 4'b0001, q: {2'b00, 1'b1, q_tab[i]}});
            tick();
            chk("jk_ev", {2'b00, b0.Ev}, 4'b0001);
            chk("jk_q", {2'b00, b0.Q}, {2'b00, 1'b1, q_tab[i]});
            tick();
            chk("jk_ev_one_cycle", {2'b00, b0.Ev}, 4'b0000);
        end

        // Clear and preset both low, preset released first, then clear
        b0.CLRn = 2'b00; b0.PREn = 2'b00; b0.Cen[0] = 1'b1;
        tick();
        chk("both_low_q", {2'b00, b0.Q}, 4'b0011);
        chk("both_low_qn", {2'b00, b0.Qn}, 4'b0011);
        b0.Cen[0] = 1'b0;
        tick();
        chk("both_low_edge_q", {2'b00, b0.Q}, 4'b0011);
        chk("both_low_edge_ev", {2'b00, b0.Ev}, 4'b0000);
        b0.PREn = 2'b11;
        tick();
        chk("pre_rel_q", {2'b00, b0.Q}, 4'b0000);
        chk("pre_rel_qn", {2'b00, b0.Qn}, 4'b0011);
        b0.Cen[0] = 1'b1; tick();
        b0.Cen[0] = 1'b0; tick();
        chk("clr_edge_ev", {2'b00, b0.Ev}, 4'b0000);
        chk("clr_edge_q", {2'b00, b0.Q}, 4'b0000);
        b0.CLRn = 2'b11;
        tick();
        chk("clr_rel_q", {2'b00, b0.Q}, 4'b0000);
        tick();
        chk("clr_no_replay_ev", {2'b00, b0.Ev}, 4'b0000);
        chk("clr_no_replay_q", {2'b00, b0.Q}, 4'b0000);

        // J/K-bar rising mode: J=1, Kbar=0 means toggle on each rise
        b1.J = 2'b11; b1.K = 2'b00;
        q1 = 2'b00;
        for (int i = 0; i < 4; i++) begin
            b1.Cen = 2'b11;
            q1 = ~q1;
            sb1.push_back('{ev: 4'b0011, q: {2'b00, q1}});
            tick();
            chk("jkbar_q", {2'b00, b1.Q}, {2'b00, q1});
            tick();
            chk("jkbar_ev_off", {2'b00, b1.Ev}, 4'b0000);
            b1.Cen = 2'b00;
            tick(); tick();
            chk("jkbar_fall_hold", {2'b00, b1.Q}, {2'b00, q1});
        end

        // Ripple counter: 16 falling pulses on Cen[0], 8 Clk apart
        b2.J = 4'hF; b2.K = 4'hF;
        c = 4'h0;
        for (int p = 0; p < 16; p++) begin
            b2.Cen[0] = 1'b1;
            for (int t = 0; t < 4; t++) begin
                b2.Cen[3:1] = 3'(p + t);
                tick();
            end
            chk("ripple_rise_hold", b2.Q, c);
            b2.Cen[0] = 1'b0;
            qe = c;
            go = 1'b1;
            for (int j = 0; j < 4; j++) begin
                b2.Cen[3:1] = 3'(p * 3 + j + 5);
                ee = 4'h0;
                if (go) begin
                    ee = 4'(1 << j);
                    qe[j] = ~qe[j];
                    go = (qe[j] == 1'b0);
                    sb2.push_back('{ev: ee, q: qe});
                end
                tick();
                chk("ripple_stage_q", b2.Q, qe);
                chk("ripple_stage_ev", b2.Ev, ee);
            end
            c = c + 4'h1;
            chk("ripple_count", b2.Q, c);
        end
        chk("ripple_wrap", b2.Q, 4'h0);

        // Reset asserted on the same Clk as a trigger edge
        b0.J[0] = 1'b1; b0.K[0] = 1'b1; b0.Cen[0] = 1'b1;
        tick(); tick();
        b0.Cen[0] = 1'b0;
        Reset = 1'b1;
        #1;
        chk("midrst_async_q", {2'b00, b0.Q}, 4'b0010);
        chk("midrst_async_qn", {2'b00, b0.Qn}, 4'b0001);
        tick();
        chk("midrst_q", {2'b00, b0.Q}, 4'b0010);
        chk("midrst_ev", {2'b00, b0.Ev}, 4'b0000);
        Reset = 1'b0;
        tick();
        tick();
        chk("midrst_lost_q", {2'b00, b0.Q}, 4'b0010);
        chk("midrst_lost_ev", {2'b00, b0.Ev}, 4'b0000);

        tick();
        chk("sb_drained", 4'(sb0.size() + sb1.size() + sb2.size()), 4'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
